// File: rtl/fp_sum_seq.sv
// Sequencer that folds a small buffer of FP32 words into one sum by driving an
// external adder over a request/complete handshake; it performs no arithmetic itself.
module fp_sum_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          clr,
  input  logic          start,
  output logic          full,
  output logic          busy,
  output logic          done,
  output logic [31:0]   sum,
  output logic [AW:0]   count,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  output logic          add_r_i,
  input  logic [31:0]   add_res,
  input  logic          add_r_o,
  output logic [2:0]    dbg_state
);

  // Adder handshake: add_r_i rises with add_a/add_b valid and stays high, with the
  // operands frozen, until the cycle after the adder's one-cycle add_r_o pulse.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FIRST = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  logic [2:0]  state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] add_a_q, add_a_d;
  logic [31:0] add_b_q, add_b_d;
  logic        req_q, req_d;
  logic        done_q, done_d;
  logic        mem_we;
  logic [31:0] mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    req_d   = req_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          count_d = '0;
        end else if (wr_en && (count_q != DEPTH_C)) begin
          mem_we  = 1'b1;
          count_d = count_q + ONE;
        end
        if (start) state_d = S_FIRST;
      end
      S_FIRST: begin
        if (count_q == '0) begin
          sum_d   = '0;
          state_d = S_FIN;
        end else if (count_q == ONE) begin
          sum_d   = mem_q[0];
          state_d = S_FIN;
        end else begin
          acc_d   = mem_q[0];
          idx_d   = ONE;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        add_a_d = acc_q;
        add_b_d = mem_q[idx_q[AW-1:0]];
        req_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (add_r_o) begin
          acc_d = add_res;
          req_d = 1'b0;
          if (idx_q == count_q - ONE) begin
            sum_d   = add_res;
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = S_ISSUE;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  // Operand storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[AW-1:0]] <= wr_data;
  end

  assign full      = (count_q == DEPTH_C);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign sum       = sum_q;
  assign count     = count_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_r_i   = req_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_sum_seq.sv
// Bench for fp_sum_seq: a behavioural FP32 adder responder plus a scoreboard of
// expected adder operand pairs and reduction results.
module tb_fp_sum_seq;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] wr_data = '0;
  logic        full, busy, done, add_r_i;
  logic [31:0] sum, add_a, add_b;
  logic [AW:0] count;
  logic [31:0] add_res = '0;
  logic        add_r_o = 1'b0;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int tx_cnt = 0;
  int ri_cycles = 0;
  bit resp_en = 1'b1;
  logic [31:0] words [0:DEPTH];
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  fp_sum_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .full(full), .busy(busy), .done(done), .sum(sum),
    .count(count), .add_a(add_a), .add_b(add_b), .add_r_i(add_r_i),
    .add_res(add_res), .add_r_o(add_r_o), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (add_r_i) ri_cycles++;

  // ---------------- FP32 reference arithmetic (normal numbers only) ----------------
  function automatic real fp2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2fp(input real xin);
    real  x, f, fl;
    logic s;
    int   e, mi;
    x = xin;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    if (s) x = -x;
    e = 127;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0) begin x = x * 2.0; e--; end
    f  = (x - 1.0) * 8388608.0;
    fl = $floor(f);
    mi = int'(fl);
    if ((f - fl) > 0.5 || ((f - fl) == 0.5 && mi[0])) mi++;
    if (mi == 8388608) begin mi = 0; e++; end
    return {s, e[7:0], mi[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2fp(fp2r(a) + fp2r(b));
  endfunction

  // Reference fold over words[0..n-1]; queues the operand pairs the adder must see.
  task automatic ref_reduce(input int n, output logic [31:0] s);
    s = '0;
    if (n > 0) s = words[0];
    for (int i = 1; i < n; i++) begin
      exp_a_q.push_back(s);
      exp_b_q.push_back(words[i]);
      s = fp_add(s, words[i]);
    end
  endtask

  // ---------------- adder responder ----------------
  initial begin : responder
    logic [31:0] a, b, ea, eb;
    int t;
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && add_r_i) begin
        a = add_a;
        b = add_b;
        checks++;
        if (exp_a_q.size() == 0) begin
          failures++;
          $display("FAIL adder_req unexpected request a=%h b=%h", a, b);
        end else begin
          ea = exp_a_q.pop_front();
          eb = exp_b_q.pop_front();
          if (a !== ea || b !== eb) begin
            failures++;
            $display("FAIL adder_operands got a=%h b=%h want a=%h b=%h", a, b, ea, eb);
          end
        end
        t = $urandom_range(0, 3);
        repeat (t) begin
          @(negedge clk);
          checks++;
          if (add_r_i !== 1'b1 || add_a !== a || add_b !== b) begin
            failures++;
            $display("FAIL adder_hold got r_i=%b a=%h b=%h want r_i=1 a=%h b=%h",
                     add_r_i, add_a, add_b, a, b);
          end
        end
        add_res = fp_add(a, b);
        add_r_o = 1'b1;
        tx_cnt++;
        @(negedge clk);
        add_r_o = 1'b0;
        add_res = $urandom;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic load_word(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Returns cycles from the start cycle to the done cycle, or -1 on timeout.
  task automatic run_reduce(output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin cyc = i + 2; break; end
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (add_r_i === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({count, sum, busy, done, add_r_i, full, add_a, add_b} !== '0) begin
      failures++;
      $display("FAIL reset_hold got count=%0d sum=%h busy=%b done=%b r_i=%b full=%b a=%h b=%h want all 0",
               count, sum, busy, done, add_r_i, full, add_a, add_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({count, sum, busy, done, add_r_i, full} !== '0) begin
      failures++;
      $display("FAIL reset_release got count=%0d sum=%h busy=%b done=%b r_i=%b full=%b want all 0",
               count, sum, busy, done, add_r_i, full);
    end
  endtask

  task automatic test_basic();
    logic [31:0] s;
    int cyc, tx0;
    do_clear();
    words[0] = 32'h3F800000; words[1] = 32'h40000000; words[2] = 32'h40400000;
    for (int i = 0; i < 3; i++) load_word(words[i]);
    ref_reduce(3, s);
    tx0 = tx_cnt;
    run_reduce(cyc);
    checks++;
    if (cyc < 0 || sum !== 32'h40C00000) begin
      failures++;
      $display("FAIL basic_sum got %h (cyc=%0d) want 40c00000", sum, cyc);
    end
    checks++;
    if (tx_cnt - tx0 != 2 || count !== 4'd3) begin
      failures++;
      $display("FAIL basic_tx_count got tx=%0d count=%0d want tx=2 count=3", tx_cnt - tx0, count);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_empty();
    int cyc, r0;
    do_clear();
    r0 = ri_cycles;
    run_reduce(cyc);
    checks++;
    if (cyc != 3 || sum !== 32'h0) begin
      failures++;
      $display("FAIL empty_sum got sum=%h latency=%0d want 00000000 latency=3", sum, cyc);
    end
    checks++;
    if (ri_cycles != r0) begin
      failures++;
      $display("FAIL empty_no_req got %0d request cycles want 0", ri_cycles - r0);
    end
  endtask

  task automatic test_single();
    int cyc, r0;
    do_clear();
    load_word(32'h40490FDB);
    r0 = ri_cycles;
    run_reduce(cyc);
    checks++;
    if (cyc != 3 || sum !== 32'h40490FDB || ri_cycles != r0) begin
      failures++;
      $display("FAIL single_sum got sum=%h latency=%0d req_cycles=%0d want 40490fdb 3 0",
               sum, cyc, ri_cycles - r0);
    end
  endtask

  task automatic test_full();
    logic [31:0] s;
    int cyc, tx0;
    do_clear();
    for (int i = 0; i < 9; i++) begin
      load_word(32'h3F800000);
      if (i == 6) begin
        checks++;
        if (full !== 1'b0) begin
          failures++;
          $display("FAIL full_early got full=%b count=%0d want full=0", full, count);
        end
      end
      if (i == 7) begin
        checks++;
        if (full !== 1'b1) begin
          failures++;
          $display("FAIL full_flag got full=%b count=%0d want full=1", full, count);
        end
      end
    end
    checks++;
    if (count !== 4'd8) begin
      failures++;
      $display("FAIL full_count got %0d want 8", count);
    end
    for (int i = 0; i < DEPTH; i++) words[i] = 32'h3F800000;
    ref_reduce(8, s);
    tx0 = tx_cnt;
    run_reduce(cyc);
    checks++;
    if (cyc < 0 || sum !== 32'h41000000 || tx_cnt - tx0 != 7) begin
      failures++;
      $display("FAIL full_sum got sum=%h tx=%0d cyc=%0d want 41000000 tx=7", sum, tx_cnt - tx0, cyc);
    end
  endtask

  task automatic test_ignore_busy();
    logic [31:0] s;
    bit ok;
    int tx0, cyc;
    do_clear();
    words[0] = 32'h3F800000; words[1] = 32'h40000000; words[2] = 32'h40400000;
    for (int i = 0; i < 3; i++) load_word(words[i]);
    ref_reduce(3, s);
    tx0 = tx_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_req got req_seen=%b busy=%b want 1 1", ok, busy);
    end
    start = 1'b1; wr_en = 1'b1; wr_data = 32'h41200000;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin cyc = i; break; end
      @(negedge clk);
    end
    checks++;
    if (cyc < 0 || sum !== 32'h40C00000 || count !== 4'd3 || tx_cnt - tx0 != 2) begin
      failures++;
      $display("FAIL busy_ignore got sum=%h count=%0d tx=%0d cyc=%0d want 40c00000 3 2",
               sum, count, tx_cnt - tx0, cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_restart got busy=%b want 0 (start during busy re-armed)", busy);
    end
    clr = 1'b1; wr_en = 1'b1; wr_data = 32'h3F800000;
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL clr_priority got count=%0d want 0", count);
    end
  endtask

  task automatic test_random();
    logic [31:0] s;
    int n, cyc;
    for (int it = 0; it < 8; it++) begin
      do_clear();
      n = $urandom_range(0, DEPTH);
      for (int i = 0; i < n; i++) begin
        words[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
        load_word(words[i]);
      end
      ref_reduce(n, s);
      run_reduce(cyc);
      checks++;
      if (cyc < 0 || sum !== s || count !== (AW+1)'(n) || exp_a_q.size() != 0) begin
        failures++;
        $display("FAIL random_sum it=%0d n=%0d got sum=%h count=%0d pending=%0d cyc=%0d want sum=%h",
                 it, n, sum, count, exp_a_q.size(), cyc, s);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    bit ok;
    int cyc;
    resp_en = 1'b0;
    do_clear();
    load_word(32'h3F800000);
    load_word(32'h40000000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_req(ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b1 || add_r_i !== 1'b1) begin
      failures++;
      $display("FAIL hang_hold got req_seen=%b busy=%b r_i=%b want 1 1 1", ok, busy, add_r_i);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (add_r_i !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid got r_i=%b busy=%b done=%b count=%0d want 0 0 0 0",
               add_r_i, busy, done, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    words[0] = 32'h3F800000; words[1] = 32'h40000000;
    load_word(words[0]);
    load_word(words[1]);
    ref_reduce(2, s);
    run_reduce(cyc);
    checks++;
    if (cyc < 0 || sum !== 32'h40400000) begin
      failures++;
      $display("FAIL reset_recover got sum=%h cyc=%0d want 40400000", sum, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_single();
    test_full();
    test_ignore_busy();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
